// File: rtl/sd_block_arbiter.sv
// Arbitrates whole-block transactions from NUM_REQ requesters onto one SD card controller port.
// Optional build macro SD_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no owner; arbitrate once a request is pending and card idle
// S_ISSUE     | owner latched; one-cycle execute pulse and request ack
// S_WAIT_BUSY | waiting for the controller to raise busy (timeout guarded)
// S_XFER      | block in flight; byte strobes/data steered to the owner
// S_RELEASE   | block finished or failed; hold grant until busy drops
module sd_block_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 32,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_wr_byte,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_byte_stb,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [7:0]                rd_byte,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      sd_op_code,
  output logic                      sd_execute,
  output logic [ADDR_W-1:0]         sd_block_address,
  output logic [7:0]                sd_outgoing_byte,
  input  logic [7:0]                sd_incoming_byte,
  input  logic                      sd_finished_byte,
  input  logic                      sd_finished_block,
  input  logic                      sd_busy
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_XFER,
    S_RELEASE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   start_idx;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               done_set;
  logic               err_set;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [7:0]         wr_arr   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign wr_arr[g]   = req_wr_byte[g*8 +: 8];
  end

`ifdef SD_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [IDX_W-1:0] ptr;
  logic             have_last;

  // Until a block has completed there is no previous winner, so the search starts at requester 0.
  always_comb begin
    start_idx = '0;
    if (have_last) begin
      start_idx = (ptr == IDX_W'(NUM_REQ - 1)) ? '0 : ptr + 1'b1;
    end
  end
`endif

  always_comb begin
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = start_idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found && !sd_busy) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A fast controller may finish the block before busy is ever seen high.
        if (sd_busy) begin
          state_nxt = S_XFER;
        end else if (sd_finished_block) begin
          done_set  = 1'b1;
          state_nxt = S_RELEASE;
        end else if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
          err_set   = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_XFER: begin
        if (sd_finished_block) begin
          done_set  = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!sd_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant            <= '0;
      owner            <= '0;
      cnt              <= '0;
      sd_op_code       <= 1'b0;
      sd_block_address <= '0;
      req_done         <= '0;
      req_err          <= '0;
`ifndef SD_ARB_FIXED_PRIO_EN
      ptr              <= '0;
      have_last        <= 1'b0;
`endif
    end else begin
      req_done <= done_set ? grant : '0;
      req_err  <= err_set  ? grant : '0;
      case (state)
        S_IDLE: begin
          if (state_nxt == S_ISSUE) begin
            grant            <= NUM_REQ'(1) << win_idx;
            owner            <= win_idx;
            sd_op_code       <= req_op[win_idx];
            sd_block_address <= addr_arr[win_idx];
          end
        end
        S_ISSUE: begin
          cnt <= '0;
        end
        S_WAIT_BUSY: begin
          cnt <= cnt_inc;
        end
        S_RELEASE: begin
`ifndef SD_ARB_FIXED_PRIO_EN
          ptr       <= owner;
          have_last <= 1'b1;
`endif
          if (!sd_busy) begin
            grant <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sd_execute       = (state == S_ISSUE);
  assign req_ack          = (state == S_ISSUE) ? grant : '0;
  assign req_byte_stb     = (state == S_XFER && sd_finished_byte) ? grant : '0;
  assign rd_byte          = (state == S_XFER) ? sd_incoming_byte : 8'h00;
  assign sd_outgoing_byte = (grant != '0) ? wr_arr[owner] : 8'h00;

endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Shares one sd_card_controller block-transfer port among NUM_REQ requesters, e.g. FAT32 metadata walker and file-data streamer.
- Arbitrates whole 512-byte block transactions. Drives the controller's op_code, execute, block_address and outgoing_byte.
- Steers incoming bytes and strobes back to the granted requester only.
- Sits between fat32-level clients and the SD card controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 32, block address width.
- BUSY_TIMEOUT, 1023, clk cycles allowed between execute pulse and sd_busy rising.

Ports:
- clk  in  1  system clock; all state updates on falling edge, matching the SD controller's sampling.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request level; held until req_ack.
- req_op  in  NUM_REQ  per-requester op: 0 read, 1 write.
- req_addr  in  NUM_REQ*ADDR_W  packed block addresses; requester i occupies slice i.
- req_wr_byte  in  NUM_REQ*8  packed outgoing write bytes.
- req_ack  out  NUM_REQ  one-cycle pulse when the request is latched.
- req_byte_stb  out  NUM_REQ  per-requester copy of sd_finished_byte.
- req_done  out  NUM_REQ  one-cycle pulse on block completion.
- req_err  out  NUM_REQ  one-cycle pulse on busy timeout.
- rd_byte  out  8  shared read data; valid with req_byte_stb.
- grant  out  NUM_REQ  one-hot owner; 0 when idle.
- sd_op_code  out  1  to controller op_code.
- sd_execute  out  1  single-cycle execute pulse.
- sd_block_address  out  ADDR_W  to controller block_address.
- sd_outgoing_byte  out  8  muxed from the granted requester.
- sd_incoming_byte  in  8  from controller.
- sd_finished_byte  in  1  from controller.
- sd_finished_block  in  1  from controller.
- sd_busy  in  1  from controller.

Behaviour:
Reset:
- Async, on rst_n low. All outputs 0, state IDLE.
- Round-robin pointer = 0, timeout counter = 0.
- Reset mid-transfer abandons the transfer silently: no done/err pulse.

IDLE:
- Arbitrates only when some req_valid is set and sd_busy=0. While the card is still initialising, requests wait.
- Round-robin: search starts at the requester after the last winner, so requester ptr+1 has highest priority.
- Winner i: grant=onehot(i), req_ack[i]=1 for one cycle.
- Latch req_op[i] into sd_op_code and req_addr slice i into sd_block_address. Both stay stable until return to IDLE.
- Go to ISSUE.

ISSUE:
- sd_execute=1 for exactly one cycle, clear timeout counter, go to WAIT_BUSY.

WAIT_BUSY:
- sd_busy=1: go to XFER.
- sd_finished_block=1 seen first (fast controller): treat as done, go to RELEASE.
- Counter reaches BUSY_TIMEOUT: req_err[i] pulse, go to RELEASE.

XFER:
- req_byte_stb[i] = sd_finished_byte & grant[i], combinational, same cycle.
- rd_byte = sd_incoming_byte.
- sd_outgoing_byte = req_wr_byte slice i.
- On sd_finished_block: req_done[i] pulse, go to RELEASE.

RELEASE:
- Update pointer to i and hold grant.
- Wait for sd_busy=0, then clear grant and go to IDLE. A back-to-back grant is possible on the next cycle.

Rules:
- Non-granted requesters never see req_byte_stb. Their req_valid and addr changes are ignored.
- A req_valid dropped before ack is never granted.
- Simultaneous requests: exactly one ack per arbitration.
- Bytes per block are not counted; the controller's finished_block is authoritative.

Optional Feature:
SD_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins; the pointer is unused and stays 0.
- Undefined: round-robin as above.
- All other timing is identical.

Test Plan:
- Single read, requester 0, addr 0x00000000: ack[0] one cycle; one sd_execute pulse; sd_block_address=0; 512 req_byte_stb[0] pulses, 0 on req_byte_stb[1]; req_done[0] once; grant returns to 0 after sd_busy falls.
- Both req_valid high from reset, addrs 0x10/0x20, round-robin: grants 0 then 1 then 0 while held high; no overlap of grant bits; addresses latched correctly per grant.
- Same stimulus with SD_ARB_FIXED_PRIO_EN defined: requester 0 wins every arbitration while it stays valid.
- sd_busy held high for 2000 cycles after reset with req_valid[1]=1: no ack until sd_busy falls, then ack[1].
- Model never raises sd_busy after execute: req_err[0] after BUSY_TIMEOUT+1 cycles, no req_done, arbiter back in IDLE.
- rst_n low midway through a 512-byte read (byte 200): all outputs 0 immediately; next request re-arbitrates from pointer 0.
